// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: command encodings, FSM states
// and the default datapath width.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic CMD_ADD = 1'b0;
    localparam logic CMD_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        HOLD   = 2'b10
    } issue_state_e;

endpackage

// File: rtl/alu_issue_stage_settle_counter.sv
// Loadable down-counter that times how long the ALU inputs are held;
// done marks the last settle cycle (count == 1).
module settle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Count register: load wins over decrement, and the count never underflows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (en && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign done = (count_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/alu_issue_stage.sv
// Sequential wrapper in front of the gate-level ALU: holds operands for a fixed
// number of settle cycles, then captures and hands off result and flags.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cmd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cmd,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carryout,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             busy,
    output logic [15:0]      op_count
);

    issue_state_e     state_r;
    issue_state_e     state_next_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             handshake_s;
    logic             capture_s;
    logic             settle_done_s;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic             alu_cmd_r;
    logic [WIDTH-1:0] out_result_r;
    logic             out_carryout_r;
    logic             out_zero_r;
    logic             out_overflow_r;
    logic [15:0]      op_count_r;

    assign accept_s    = in_valid && in_ready_s;
    assign handshake_s = (state_r == HOLD) && out_ready;
    assign capture_s   = (state_r == SETTLE) && settle_done_s;

    settle_counter #(
        .CNT_W (CNT_W)
    ) u_settle_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept_s),
        .load_value (CNT_W'(SETTLE_CYCLES)),
        .en         (state_r == SETTLE),
        .done       (settle_done_s)
    );

    // Next-state and upstream ready; HOLD passes out_ready through so a
    // completing handshake can accept the next request on the same edge.
    always_comb begin
        state_next_s = state_r;
        in_ready_s   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (accept_s) begin
                    state_next_s = SETTLE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETTLE: begin
                in_ready_s = 1'b0;
                if (settle_done_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = SETTLE;
                end
            end
            HOLD: begin
                in_ready_s = out_ready;
                if (out_ready && in_valid) begin
                    state_next_s = SETTLE;
                end else if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                in_ready_s   = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand registers change only when a request is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a_r   <= {WIDTH{1'b0}};
            alu_b_r   <= {WIDTH{1'b0}};
            alu_cmd_r <= CMD_ADD;
        end else if (accept_s) begin
            alu_a_r   <= in_a;
            alu_b_r   <= in_b;
            alu_cmd_r <= in_cmd;
        end
    end

    // Capture registers sample the settled ALU outputs on the last settle edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_result_r   <= {WIDTH{1'b0}};
            out_carryout_r <= 1'b0;
            out_zero_r     <= 1'b0;
            out_overflow_r <= 1'b0;
        end else if (capture_s) begin
            out_result_r   <= alu_result;
            out_carryout_r <= alu_carryout;
            out_zero_r     <= alu_zero;
            out_overflow_r <= alu_overflow;
        end
    end

    // Completed-handshake counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count_r <= 16'h0000;
        end else if (handshake_s) begin
            op_count_r <= op_count_r + 16'h0001;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = (state_r == HOLD);
    assign busy         = (state_r == SETTLE) || (state_r == HOLD);
    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign alu_cmd      = alu_cmd_r;
    assign out_result   = out_result_r;
    assign out_carryout = out_carryout_r;
    assign out_zero     = out_zero_r;
    assign out_overflow = out_overflow_r;
    assign op_count     = op_count_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU stand-in and
// directed vectors whose expected results are written out by hand.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_cmd = 1'b0;
    logic [W-1:0]  alu_a, alu_b;
    logic          alu_cmd;
    logic [W-1:0]  alu_result;
    logic          alu_carryout, alu_zero, alu_overflow;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_result;
    logic          out_carryout, out_zero, out_overflow;
    logic          busy;
    logic [15:0]   op_count;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         o;
        int unsigned  acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          errors = 0;
    logic [15:0] exp_ops = 16'h0000;
    logic        presented = 1'b0;

    alu_issue_stage #(.WIDTH(W), .SETTLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cmd(in_cmd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
        .alu_result(alu_result), .alu_carryout(alu_carryout),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carryout(out_carryout),
        .out_zero(out_zero), .out_overflow(out_overflow),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU stand-in: SUB is A + ~B + 1.
    logic [W-1:0] b_eff;
    logic [W:0]   sum;
    always_comb begin
        b_eff        = alu_cmd ? ~alu_b : alu_b;
        sum          = {1'b0, alu_a} + {1'b0, b_eff} + {{W{1'b0}}, alu_cmd};
        alu_result   = sum[W-1:0];
        alu_carryout = sum[W];
        alu_zero     = (sum[W-1:0] == '0);
        alu_overflow = (alu_a[W-1] == b_eff[W-1]) && (sum[W-1] != alu_a[W-1]);
    end

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: latency check when a result first appears, data check on handshake.
    always @(negedge clk) begin
        if (reset) begin
            presented = 1'b0;
        end else begin
            if (out_valid && !presented) begin
                presented = 1'b1;
                if (sb_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_result: got %0h, expected none", out_result);
                end else begin
                    check1("latency", 64'(cyc - sb_q[0].acc_cyc), 64'(SC));
                end
            end
            if (out_valid && out_ready) begin
                presented = 1'b0;
                if (sb_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_handshake: got %0h, expected none", out_result);
                end else begin
                    check1("out_result",   64'(out_result),   64'(sb_q[0].res));
                    check1("out_carryout", 64'(out_carryout), 64'(sb_q[0].c));
                    check1("out_zero",     64'(out_zero),     64'(sb_q[0].z));
                    check1("out_overflow", 64'(out_overflow), 64'(sb_q[0].o));
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request and wait (bounded) for it to be accepted.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cmd,
                         input logic [W-1:0] er, input logic ec, input logic ez, input logic eo);
        exp_t e;
        bit   done = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_cmd = cmd;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = er; e.c = ec; e.z = ez; e.o = eo; e.acc_cyc = cyc + 1;
                sb_q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            vectors++; errors++;
            $display("FAIL accept_timeout: got in_ready 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            vectors++; errors++;
            $display("FAIL valid_timeout: got out_valid 0, expected 1");
        end
    endtask

    task automatic chk_ops();
        @(negedge clk);
        check1("op_count", 64'(op_count), 64'(exp_ops));
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        check1("rst_in_ready",  64'(in_ready),   64'd1);
        check1("rst_out_valid", 64'(out_valid),  64'd0);
        check1("rst_busy",      64'(busy),       64'd0);
        check1("rst_op_count",  64'(op_count),   64'd0);
        check1("rst_alu_a",     64'(alu_a),      64'd0);
        check1("rst_out_result",64'(out_result), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADD wrap and SUB overflow with no backpressure
        issue(32'h0000_0001, 32'hFFFF_FFFF, CMD_ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        step(6); exp_ops = exp_ops + 16'h1; chk_ops();
        issue(32'h8000_0000, 32'h4000_0001, CMD_SUB, 32'h3FFF_FFFF, 1'b1, 1'b0, 1'b1);
        step(6); exp_ops = exp_ops + 16'h1; chk_ops();

        // Backpressure: everything frozen while out_ready is low
        out_ready = 1'b0;
        issue(32'h0000_0005, 32'h0000_0005, CMD_SUB, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            check1("bp_out_valid", 64'(out_valid),    64'd1);
            check1("bp_out_result",64'(out_result),   64'd0);
            check1("bp_carry",     64'(out_carryout), 64'd1);
            check1("bp_zero",      64'(out_zero),     64'd1);
            check1("bp_in_ready",  64'(in_ready),     64'd0);
            check1("bp_alu_a",     64'(alu_a),        64'd5);
            check1("bp_alu_b",     64'(alu_b),        64'd5);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        step(2); exp_ops = exp_ops + 16'h1; chk_ops();

        // Back-to-back: second request accepted on the HOLD exit edge
        out_ready = 1'b0;
        issue(32'h0000_0002, 32'h0000_0003, CMD_ADD, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, CMD_ADD, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check1("b2b_busy",      64'(busy),      64'd1);
        check1("b2b_out_valid", 64'(out_valid), 64'd0);
        check1("b2b_in_ready",  64'(in_ready),  64'd0);
        check1("b2b_alu_a",     64'(alu_a),     64'h7FFF_FFFF);
        @(posedge clk); #1;
        step(6); exp_ops = exp_ops + 16'h2; chk_ops();

        // Asynchronous reset mid-SETTLE aborts the request
        issue(32'h0000_1234, 32'h0000_1111, CMD_ADD, 32'h0000_2345, 1'b0, 1'b0, 1'b0);
        step(1);
        #2;
        reset = 1'b1;
        #1;
        check1("abort_in_ready",  64'(in_ready),  64'd1);
        check1("abort_out_valid", 64'(out_valid), 64'd0);
        check1("abort_busy",      64'(busy),      64'd0);
        check1("abort_op_count",  64'(op_count),  64'd0);
        check1("abort_alu_a",     64'(alu_a),     64'd0);
        void'(sb_q.pop_back());
        exp_ops = 16'h0000;
        @(posedge clk); #1;
        reset = 1'b0;
        step(8);
        @(negedge clk);
        check1("abort_no_result", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // op_count wrap from 0xFFFF
        out_ready = 1'b0;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, CMD_ADD, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        wait_valid();
        force dut.op_count_r = 16'hFFFF;
        #1;
        release dut.op_count_r;
        #1;
        check1("wrap_preload", 64'(op_count), 64'hFFFF);
        @(posedge clk); #1;
        out_ready = 1'b1;
        step(2); exp_ops = 16'h0000; chk_ops();

        step(2);
        check1("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Sequential wrapper directly upstream of the gate-level 32-bit ALU.
- Accepts one operand pair plus command from the decode/register-read side over a valid/ready handshake.
- Holds the operands stable on the ALU inputs for a fixed number of settle cycles, because the gate-level adder ripple delay spans several clock periods.
- Captures result and flags, then presents them downstream over a second valid/ready handshake.

Parameters:
- WIDTH, 32, datapath width; must match the ALU operand width.
- SETTLE_CYCLES, 4, whole clock cycles the ALU inputs are held before capture; legal range 1..255.
- CNT_W, 8, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  stage can accept a request this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cmd  in  1  ALU command: 0 = ADD, 1 = SUB.
- alu_a  out  WIDTH  registered operand A to ALU operandA.
- alu_b  out  WIDTH  registered operand B to ALU operandB.
- alu_cmd  out  1  registered command to ALU command.
- alu_result  in  WIDTH  ALU result.
- alu_carryout  in  1  ALU carryout.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU overflow flag.
- out_valid  out  1  captured result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  WIDTH  captured result.
- out_carryout  out  1  captured carryout.
- out_zero  out  1  captured zero flag.
- out_overflow  out  1  captured overflow flag.
- busy  out  1  high in SETTLE or HOLD.
- op_count  out  16  count of completed output handshakes; wraps 0xFFFF -> 0.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state = IDLE; all outputs 0 except in_ready = 1. This covers alu_a/alu_b/alu_cmd, out_*, busy and op_count.
- Reset asserted mid-operation aborts the operation. The in-flight result is discarded and is never presented.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - SETTLE: in_ready = 0, out_valid = 0.
  - HOLD: out_valid = 1, in_ready = out_ready.
- Accept: occurs on a clock edge where in_valid && in_ready.
  - At that edge, alu_a/alu_b/alu_cmd load in_a/in_b/in_cmd.
  - The settle counter loads SETTLE_CYCLES and state goes to SETTLE.
- SETTLE:
  - Each edge decrements the counter.
  - On the edge where the counter equals 1, out_result/out_carryout/out_zero/out_overflow capture the alu_* inputs and state goes to HOLD.
  - out_valid therefore rises exactly SETTLE_CYCLES edges after the accept edge.
  - With SETTLE_CYCLES = 1, capture occurs on the first edge after accept.
- ALU inputs are stable: alu_a/alu_b/alu_cmd change only on an accept edge. They never change during SETTLE or HOLD.
- Output registers: out_* change only on a capture edge. They hold their value after the handshake until the next capture.
- HOLD exit on an edge where out_ready = 1:
  - op_count increments.
  - If in_valid is also 1, the new request is accepted on the same edge and state goes directly to SETTLE. This is back-to-back issue with no IDLE bubble.
  - Otherwise state goes to IDLE.
- HOLD with out_ready = 0: stall. out_* are held and no request is accepted.
- Upstream rule: in_a/in_b/in_cmd are ignored whenever no accept occurs. Upstream must hold them stable while in_valid is high and in_ready is low.
- Flags: no arithmetic is done in this block; flags pass straight through.
- System constraint: SETTLE_CYCLES × clock period must exceed the worst-case ALU path, including the zero-flag chain.

Decomposition:
- Shared package alu_pkg:
  - ALU command constants CMD_ADD = 1'b0, CMD_SUB = 1'b1.
  - State enumeration IDLE/SETTLE/HOLD, 2-bit encoding.
  - WIDTH default.
- One sub-module, settle_counter: loadable down-counter with inputs load, load_value, en and output done (count == 1).
- The FSM, operand registers and capture registers stay in alu_issue_stage.

Test Plan:
- Reset:
  - Stimulus: assert reset asynchronously mid-SETTLE.
  - Response: state IDLE, in_ready = 1, out_valid = 0, op_count = 0 immediately without waiting for a clock edge. No result ever appears for the aborted request.
- ADD wrap:
  - Stimulus: in_a = 0x00000001, in_b = 0xFFFFFFFF, in_cmd = 0, SETTLE_CYCLES = 4.
  - Response: out_valid exactly 4 edges after accept; out_result = 0x00000000, carry = 1, zero = 1, ovfl = 0.
- SUB overflow:
  - Stimulus: in_a = 0x80000000, in_b = 0x40000001, in_cmd = 1.
  - Response: out_result = 0x3FFFFFFF, carry = 1, zero = 0, ovfl = 1.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles after out_valid.
  - Response: out_* stable, in_ready = 0, alu_a/alu_b unchanged. When out_ready = 1, op_count increments by exactly 1.
- Back-to-back:
  - Stimulus: out_ready = 1 and in_valid = 1 with a second request (0x7FFFFFFF + 0x7FFFFFFF ADD) in the HOLD cycle.
  - Response: direct HOLD -> SETTLE; second out_result = 0xFFFFFFFE, carry = 0, ovfl = 1, SETTLE_CYCLES edges later.
- op_count wrap:
  - Stimulus: force op_count to 0xFFFF, then complete one handshake.
  - Response: op_count = 0x0000.
